ahb5_slave_mem: RTL and testbench
=================================

// Module: ahb5_slave_mem
// PURPOSE
//  AHB5 subordinate memory: the downstream consumer of the ahb5_driver clocking-block signals.
//  Decodes address/data-phase pipelined transfers and services byte/half/word accesses to an internal RAM.
//  Returns OKAY or two-cycle ERROR on Hresp and drives Hready/Hrdata back to the master.
//  Serves as the RTL DUT for the AHB5 master VIP bench.
// PARAMETERS
//  DATA_WIDTH   32    data bus width, 8..1024, power of 2
//  ADDR_WIDTH   32    address bus width
//  MEM_BYTES    4096  RAM size in bytes, multiple of DATA_WIDTH/8; valid range 0..MEM_BYTES-1
//  WAIT_STATES  0     wait cycles per OKAY data phase, 0..15 (used only with AHB5_SLV_WAIT_EN)
// PORTS
//  Hclk     in   1           bus clock, all state on rising edge
//  HResetn  in   1           asynchronous active-low reset
//  Hsel     in   1           subordinate select
//  Haddr    in   ADDR_WIDTH  byte address
//  Htrans   in   2           IDLE=0 BUSY=1 NONSEQ=2 SEQ=3
//  Hwrite   in   1           1=write 0=read
//  Hsize    in   3           bytes = 2**Hsize
//  Hburst   in   3           burst type, informational only (not checked)
//  Hwdata   in   DATA_WIDTH  write data, valid in data phase
//  Hready   out  1           data phase complete / bus ready
//  Hresp    out  1           0=OKAY 1=ERROR
//  Hrdata   out  DATA_WIDTH  read data, valid when Hready=1 in a read data phase
// BEHAVIOUR
//  Reset: Hready=1, Hresp=0, Hrdata=0, FSM=IDLE, no pending phase; RAM contents not reset.
//  Address phase accepted on rising edge when Hsel & Htrans[1] & Hready; Haddr/Hwrite/Hsize latched.
//  IDLE/BUSY or Hsel=0: no access, zero-wait OKAY in following cycle.
//  Error check at acceptance: Haddr>=MEM_BYTES, Hsize>log2(DATA_WIDTH/8), or Haddr not 2**Hsize aligned.
//  FSM: IDLE -> ACCESS (ok) | ERR1 (error); ACCESS -> WAIT when wait count>0, else completes;
//   WAIT counts down to 0 then completes; ERR1 -> ERR2 -> IDLE/ACCESS/ERR1 per next accepted phase.
//  ERROR: ERR1 Hready=0 Hresp=1; ERR2 Hready=1 Hresp=1. Erroneous write never modifies RAM;
//   erroneous read returns Hrdata=0. Address phase during ERR1 ignored; during ERR2 accepted normally.
//  Write: Hwdata byte lanes selected by latched Haddr low bits and Hsize; RAM updated on the edge
//   that completes the data phase (Hready=1). Other lanes untouched.
//  Read: RAM read at address-phase acceptance, Hrdata registered; full bus word returned (all lanes).
//  Hazard: read address phase overlapping a write data phase to the same word -> forwarded write
//   bytes merged into Hrdata (read-after-write returns new data, zero extra cycles).
//  Back-to-back NONSEQ/SEQ: one transfer per cycle at 0 wait states; pipelined phases never stall.
//  Reset mid-transfer: pending write dropped, FSM->IDLE immediately, outputs to reset values.
// CONFIGURATION
//  AHB5_SLV_WAIT_EN defined: each OKAY data phase holds Hready=0 for WAIT_STATES cycles (Hresp=0),
//   address sampling frozen while Hready=0, Hwdata sampled on completing edge.
//  Undefined: WAIT_STATES ignored, every OKAY transfer zero-wait; no wait counter synthesised.
// STRUCTURE
//  ahb5_pkg: htrans_e (IDLE/BUSY/NONSEQ/SEQ), hsize_e, hburst_e, HRESP_OKAY/HRESP_ERROR,
//   slv_state_e (IDLE/ACCESS/WAIT/ERR1/ERR2).
//  Sub-module ahb5_slv_ram: single-port byte-enable RAM, DATA_WIDTH wide, MEM_BYTES/(DATA_WIDTH/8)
//   deep, synchronous write, registered read.
//  Top holds phase registers, error decode, forwarding mux, FSM and wait counter.
// TESTING
//  1 Reset: HResetn=0 mid write -> Hready=1 Hresp=0 Hrdata=0; target word unchanged after release.
//  2 Word write 0x10=0xDEADBEEF then read 0x10 back-to-back -> Hrdata=0xDEADBEEF, OKAY, 0 waits.
//  3 Byte write 0x13=0xA5 over 0x11223344 -> read 0x10 returns 0xA5223344.
//  4 Read 0x1000 (MEM_BYTES=4096) -> ERR1 Hready=0 Hresp=1, ERR2 Hready=1 Hresp=1, Hrdata=0.
//  5 Halfword at 0x21 (unaligned) write -> ERROR, read 0x20 unchanged; BUSY cycle -> OKAY, no access.
//  6 AHB5_SLV_WAIT_EN, WAIT_STATES=2, INCR4 writes 0x40..0x4C -> each beat 2 Hready=0 cycles, data correct.

Source files
------------

// File: rtl/ahb5_pkg.sv
// ---------------------------------------------------------------------------
// ahb5_pkg
// Shared AHB5 encodings for the subordinate memory: transfer type, size and
// burst enumerations, response codes and the subordinate FSM state type.
// No ports; imported by ahb5_slv_ram and ahb5_slave_mem.
// ---------------------------------------------------------------------------
package ahb5_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE   = 3'd0,
        HSIZE_HALF   = 3'd1,
        HSIZE_WORD   = 3'd2,
        HSIZE_DWORD  = 3'd3,
        HSIZE_4WORD  = 3'd4,
        HSIZE_8WORD  = 3'd5,
        HSIZE_16WORD = 3'd6,
        HSIZE_32WORD = 3'd7
    } hsize_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Explicit encodings keep the state register readable in waveforms and
    // stable across tool versions.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ERR1   = 3'd3,
        ST_ERR2   = 3'd4
    } slv_state_e;

endpackage

// File: rtl/ahb5_slv_ram.sv
// ---------------------------------------------------------------------------
// ahb5_slv_ram
// Byte-enable RAM, DATA_WIDTH wide and DEPTH words deep. One write and one
// read per clock so a pipelined write data phase and the next read address
// phase can be serviced in the same cycle. Read is registered and returns
// the contents from before a same-cycle write (the top forwards around it).
// Ports:
//   clk    in   clock
//   we     in   write enable
//   be     in   per-byte write enables
//   waddr  in   write word index
//   wdata  in   write data
//   re     in   read enable (rdata holds when low)
//   raddr  in   read word index
//   rdata  out  registered read data
// ---------------------------------------------------------------------------
module ahb5_slv_ram
    import ahb5_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 1024,
    localparam int STRB       = DATA_WIDTH / 8,
    localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [STRB-1:0]       be,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset branch on purpose; resetting a memory
    // turns it into a bank of flops and stops it mapping onto RAM macros.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < STRB; b++) begin
                if (be[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ahb5_slave_mem.sv
// ---------------------------------------------------------------------------
// ahb5_slave_mem
// AHB5 subordinate backed by an internal byte-enable RAM. Accepts pipelined
// address/data-phase transfers of byte..bus-width size, answers OKAY or a
// two-cycle ERROR, and forwards write data into an overlapping read of the
// same word so read-after-write costs no extra cycles.
// Optional build macro: AHB5_SLV_WAIT_EN -- when defined every OKAY data
// phase is stretched by WAIT_STATES cycles of Hready=0.
// Ports:
//   Hclk     in   bus clock
//   HResetn  in   asynchronous active-low reset
//   Hsel     in   subordinate select
//   Haddr    in   byte address
//   Htrans   in   transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   Hwrite   in   1 = write, 0 = read
//   Hsize    in   transfer size, 2**Hsize bytes
//   Hburst   in   burst type (not used by the decode)
//   Hwdata   in   write data, data phase
//   Hready   out  data phase complete
//   Hresp    out  0 = OKAY, 1 = ERROR
//   Hrdata   out  read data
// ---------------------------------------------------------------------------
module ahb5_slave_mem
    import ahb5_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_BYTES   = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic                  Hclk,
    input  logic                  HResetn,
    input  logic                  Hsel,
    input  logic [ADDR_WIDTH-1:0] Haddr,
    input  logic [1:0]            Htrans,
    input  logic                  Hwrite,
    input  logic [2:0]            Hsize,
    input  logic [2:0]            Hburst,
    input  logic [DATA_WIDTH-1:0] Hwdata,
    output logic                  Hready,
    output logic                  Hresp,
    output logic [DATA_WIDTH-1:0] Hrdata
);

    localparam int STRB      = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(STRB);
    localparam int OFF_W     = (LANE_BITS > 0) ? LANE_BITS : 1;
    localparam int DEPTH     = MEM_BYTES / STRB;
    localparam int WORD_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    slv_state_e            state;
    logic                  wr_pend;
    logic                  rd_valid;
    logic [WORD_W-1:0]     ph_word;
    logic [STRB-1:0]       ph_be;
    logic [STRB-1:0]       fwd_be;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [DATA_WIDTH-1:0] ram_rdata;

`ifdef AHB5_SLV_WAIT_EN
    logic [3:0]            wait_cnt;
`else
    localparam int wait_states_unused = WAIT_STATES;
`endif

    // Burst type is informational only; the decode treats every beat alike.
    logic unused_hburst;
    assign unused_hburst = ^Hburst;

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    logic              accept;
    logic              acc_err;
    logic              addr_oob;
    logic              size_bad;
    logic              misaligned;
    logic [WORD_W-1:0] acc_word;
    logic [OFF_W-1:0]  acc_off;
    logic [STRB-1:0]   acc_be;

    assign accept   = Hsel && (Htrans == HTRANS_NONSEQ || Htrans == HTRANS_SEQ) && Hready;
    assign addr_oob = 64'(Haddr) >= 64'(MEM_BYTES);
    assign size_bad = Hsize > 3'(LANE_BITS);
    assign acc_err  = addr_oob || size_bad || misaligned;
    assign acc_word = WORD_W'(Haddr >> LANE_BITS);
    assign acc_off  = OFF_W'(Haddr & ADDR_WIDTH'(STRB - 1));

    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        misaligned = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i < int'(Hsize) && Haddr[i]) begin
                misaligned = 1'b1;
            end
        end
    end

    // Lanes covered by an aligned transfer: [offset, offset + 2**Hsize).
    always_comb begin
        acc_be = '0;
        for (int b = 0; b < STRB; b++) begin
            if (b >= int'(acc_off) && b < int'(acc_off) + (1 << Hsize)) begin
                acc_be[b] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response outputs, decoded from the FSM state
    // ------------------------------------------------------------------
    always_comb begin
        Hready = 1'b1;
        case (state)
            ST_ERR1:   Hready = 1'b0;
`ifdef AHB5_SLV_WAIT_EN
            ST_ACCESS: Hready = (WAIT_STATES == 0);
            ST_WAIT:   Hready = (wait_cnt == 4'd0);
`endif
            default:   Hready = 1'b1;
        endcase
    end

    assign Hresp = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;

    // ------------------------------------------------------------------
    // RAM control
    // ------------------------------------------------------------------
    logic data_done;
    logic ram_we;
    logic ram_re;

    assign data_done = Hready && (state == ST_ACCESS || state == ST_WAIT);
    assign ram_we    = data_done && wr_pend;
    assign ram_re    = accept && !acc_err && !Hwrite;

    ahb5_slv_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (Hclk),
        .we    (ram_we),
        .be    (ph_be),
        .waddr (ph_word),
        .wdata (Hwdata),
        .re    (ram_re),
        .raddr (acc_word),
        .rdata (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Phase registers, forwarding capture and FSM
    // ------------------------------------------------------------------
    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Hclk or negedge HResetn) begin
        if (!HResetn) begin
            state    <= ST_IDLE;
            wr_pend  <= 1'b0;
            rd_valid <= 1'b0;
            ph_word  <= '0;
            ph_be    <= '0;
            fwd_be   <= '0;
            fwd_data <= '0;
`ifdef AHB5_SLV_WAIT_EN
            wait_cnt <= 4'd0;
`endif
        end else if (Hready) begin
            wr_pend  <= accept && !acc_err && Hwrite;
            rd_valid <= ram_re;
            if (accept) begin
                ph_word <= acc_word;
                ph_be   <= acc_be;
            end
            // The RAM read above sees the old word when a write to it lands
            // on this same edge; capture the written lanes to patch Hrdata.
            if (ram_re && ram_we && ph_word == acc_word) begin
                fwd_be   <= ph_be;
                fwd_data <= Hwdata;
            end else begin
                fwd_be   <= '0;
            end
            if (!accept) begin
                state <= ST_IDLE;
            end else if (acc_err) begin
                state <= ST_ERR1;
            end else begin
                state <= ST_ACCESS;
            end
        end else begin
            case (state)
                ST_ERR1: state <= ST_ERR2;
`ifdef AHB5_SLV_WAIT_EN
                // ACCESS itself is the first wait cycle, so WAIT holds for
                // the remaining WAIT_STATES-1 before completing.
                ST_ACCESS: begin
                    state    <= ST_WAIT;
                    wait_cnt <= 4'(WAIT_STATES - 1);
                end
                ST_WAIT: wait_cnt <= wait_cnt - 4'd1;
`endif
                default: state <= state;
            endcase
        end
    end

    // Full bus word returned; forwarded lanes override the stale RAM read.
    always_comb begin
        Hrdata = '0;
        if (rd_valid) begin
            for (int b = 0; b < STRB; b++) begin
                Hrdata[b*8 +: 8] = fwd_be[b] ? fwd_data[b*8 +: 8] : ram_rdata[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb5_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_ahb5_slave_mem
// Directed self-checking bench for ahb5_slave_mem (32-bit bus, 4 KiB RAM,
// WAIT_STATES=2). Inputs change 1 time unit after the rising edge; outputs
// are sampled on the falling edge. Expected wait count follows the
// AHB5_SLV_WAIT_EN build macro.
// ---------------------------------------------------------------------------
module tb_ahb5_slave_mem;
    import ahb5_pkg::*;

`ifdef AHB5_SLV_WAIT_EN
    localparam int EXP_WAITS = 2;
`else
    localparam int EXP_WAITS = 0;
`endif

    logic        Hclk;
    logic        HResetn;
    logic        Hsel;
    logic [31:0] Haddr;
    logic [1:0]  Htrans;
    logic        Hwrite;
    logic [2:0]  Hsize;
    logic [2:0]  Hburst;
    logic [31:0] Hwdata;
    logic        Hready;
    logic        Hresp;
    logic [31:0] Hrdata;

    int checks   = 0;
    int failures = 0;

    ahb5_slave_mem #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .MEM_BYTES   (4096),
        .WAIT_STATES (2)
    ) dut (
        .Hclk    (Hclk),
        .HResetn (HResetn),
        .Hsel    (Hsel),
        .Haddr   (Haddr),
        .Htrans  (Htrans),
        .Hwrite  (Hwrite),
        .Hsize   (Hsize),
        .Hburst  (Hburst),
        .Hwdata  (Hwdata),
        .Hready  (Hready),
        .Hresp   (Hresp),
        .Hrdata  (Hrdata)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive the address phase for this cycle plus the write
    // data for the previous address phase, then wait for the sample point.
    task automatic cyc(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wd);
        @(posedge Hclk);
        #1;
        Hsel   = sel;
        Htrans = trans;
        Hwrite = wr;
        Hsize  = size;
        Haddr  = addr;
        Hwdata = wd;
        @(negedge Hclk);
    endtask

    task automatic idle(input logic [31:0] wd);
        cyc(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, wd);
    endtask

    // Hold all inputs while Hready is low; report the number of wait cycles.
    task automatic settle(output int n);
        n = 0;
        while (Hready !== 1'b1 && n < 20) begin
            n++;
            @(posedge Hclk);
            #1;
            @(negedge Hclk);
        end
    endtask

    initial begin
        int n;
        logic [31:0] beat [4];

        Hsel    = 1'b0;
        Htrans  = HTRANS_IDLE;
        Hwrite  = 1'b0;
        Hsize   = HSIZE_WORD;
        Haddr   = 32'h0;
        Hburst  = HBURST_SINGLE;
        Hwdata  = 32'h0;
        HResetn = 1'b0;
        for (int i = 0; i < 4; i++) beat[i] = 32'hA0B0C0D0 + 32'(i) * 32'h01010101;

        // Power-on reset values
        repeat (2) @(negedge Hclk);
        check("rst_hready", 32'(Hready), 32'd1);
        check("rst_hresp",  32'(Hresp),  32'd0);
        check("rst_hrdata", Hrdata,      32'h0);
        @(posedge Hclk);
        #1;
        HResetn = 1'b1;

        // Word write then back-to-back read of the same word (forwarded)
        cyc(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'h0);
        settle(n);
        cyc(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'hDEADBEEF);
        settle(n);
        check("raw_wr_waits", 32'(n), 32'(EXP_WAITS));
        check("raw_wr_resp",  32'(Hresp), 32'd0);
        idle(32'h0);
        settle(n);
        check("raw_rd_waits", 32'(n), 32'(EXP_WAITS));
        check("raw_rd_resp",  32'(Hresp), 32'd0);
        check("raw_rd_data",  Hrdata, 32'hDEADBEEF);

        // Byte write into a word, lanes outside the byte must be untouched
        cyc(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'h0);
        settle(n);
        cyc(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h13, 32'h11223344);
        settle(n);
        idle(32'hA5FFFFFF);
        settle(n);
        cyc(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
        settle(n);
        idle(32'h0);
        settle(n);
        check("byte_merge", Hrdata, 32'hA5223344);

        // Byte write immediately followed by a read of the same word
        cyc(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h11, 32'h0);
        settle(n);
        cyc(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'hEEEE77EE);
        settle(n);
        idle(32'h0);
        settle(n);
        check("fwd_byte", Hrdata, 32'hA5227744);

        // Upper halfword write
        cyc(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h12, 32'h0);
        settle(n);
        idle(32'hBEEF1234);
        settle(n);
        cyc(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0);
        settle(n);
        idle(32'h0);
        settle(n);
        check("half_upper", Hrdata, 32'hBEEF7744);

        // Reset asserted during a read data phase clears the outputs at once
        #2;
        HResetn = 1'b0;
        #1;
        check("rst_rd_hready", 32'(Hready), 32'd1);
        check("rst_rd_hresp",  32'(Hresp),  32'd0);
        check("rst_rd_hrdata", Hrdata,      32'h0);
        @(posedge Hclk);
        #1;
        HResetn = 1'b1;

        // Reset asserted during a write data phase drops the write
        cyc(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h30, 32'h0);
        settle(n);
        idle(32'h55AA55AA);
        settle(n);
        cyc(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h30, 32'h0);
        settle(n);
        idle(32'h0BADF00D);
        HResetn = 1'b0;
        #1;
        check("rst_wr_hready", 32'(Hready), 32'd1);
        check("rst_wr_hresp",  32'(Hresp),  32'd0);
        check("rst_wr_hrdata", Hrdata,      32'h0);
        @(posedge Hclk);
        #1;
        HResetn = 1'b1;
        cyc(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h30, 32'h0);
        settle(n);
        idle(32'h0);
        settle(n);
        check("rst_wr_dropped", Hrdata, 32'h55AA55AA);

        // Out-of-range read: two-cycle ERROR, no data
        cyc(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h1000, 32'h0);
        settle(n);
        idle(32'h0);
        check("oob_err1_hready", 32'(Hready), 32'd0);
        check("oob_err1_hresp",  32'(Hresp),  32'd1);
        idle(32'h0);
        check("oob_err2_hready", 32'(Hready), 32'd1);
        check("oob_err2_hresp",  32'(Hresp),  32'd1);
        check("oob_err2_hrdata", Hrdata,      32'h0);
        idle(32'h0);
        check("oob_after_hresp", 32'(Hresp), 32'd0);

        // Last valid word of the RAM
        cyc(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'hFFC, 32'h0);
        settle(n);
        cyc(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'hFFC, 32'h0F0F0F0F);
        settle(n);
        check("top_word_wr_resp", 32'(Hresp), 32'd0);
        idle(32'h0);
        settle(n);
        check("top_word_rd", Hrdata, 32'h0F0F0F0F);

        // Unaligned halfword write is rejected and leaves RAM alone
        cyc(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20, 32'h0);
        settle(n);
        idle(32'hCAFEF00D);
        settle(n);
        cyc(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h21, 32'h0);
        settle(n);
        idle(32'h12345678);
        check("unal_err1_hready", 32'(Hready), 32'd0);
        check("unal_err1_hresp",  32'(Hresp),  32'd1);
        idle(32'h12345678);
        check("unal_err2_hready", 32'(Hready), 32'd1);
        check("unal_err2_hresp",  32'(Hresp),  32'd1);

        // Size larger than the bus is rejected
        cyc(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_DWORD, 32'h20, 32'h0);
        idle(32'h0);
        check("size_err1_hresp", 32'(Hresp), 32'd1);
        idle(32'h0);
        check("size_err2_hresp", 32'(Hresp), 32'd1);

        // BUSY and unselected transfers: zero-wait OKAY, no RAM access
        cyc(1'b1, HTRANS_BUSY, 1'b1, HSIZE_WORD, 32'h20, 32'h0);
        settle(n);
        cyc(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20, 32'h77777777);
        check("busy_hready", 32'(Hready), 32'd1);
        check("busy_hresp",  32'(Hresp),  32'd0);
        idle(32'h88888888);
        check("nosel_hready", 32'(Hready), 32'd1);
        check("nosel_hresp",  32'(Hresp),  32'd0);
        cyc(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'h0);
        settle(n);
        idle(32'h0);
        settle(n);
        check("unal_busy_unchanged", Hrdata, 32'hCAFEF00D);

        // Address phase during ERR1 is ignored, during ERR2 accepted
        cyc(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h1000, 32'h0);
        settle(n);
        cyc(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20, 32'h0);
        check("err1_ignore_hready", 32'(Hready), 32'd0);
        cyc(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'h99999999);
        check("err2_accept_hresp", 32'(Hresp), 32'd1);
        idle(32'h0);
        settle(n);
        check("after_err2_hresp", 32'(Hresp), 32'd0);
        check("after_err2_data",  Hrdata,     32'hCAFEF00D);

        // INCR4 write burst, then INCR4 read burst of the same words
        Hburst = HBURST_INCR4;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                cyc(1'b1, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1, HSIZE_WORD,
                    32'h40 + 32'(i) * 32'd4, (i > 0) ? beat[(i > 0) ? i - 1 : 0] : 32'h0);
            end else begin
                idle(beat[3]);
            end
            settle(n);
            if (i > 0) begin
                check($sformatf("incr4_wr_waits_%0d", i - 1), 32'(n), 32'(EXP_WAITS));
                check($sformatf("incr4_wr_resp_%0d", i - 1), 32'(Hresp), 32'd0);
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                cyc(1'b1, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b0, HSIZE_WORD,
                    32'h40 + 32'(i) * 32'd4, 32'h0);
            end else begin
                idle(32'h0);
            end
            settle(n);
            if (i > 0) begin
                check($sformatf("incr4_rd_waits_%0d", i - 1), 32'(n), 32'(EXP_WAITS));
                check($sformatf("incr4_rd_data_%0d", i - 1), Hrdata, beat[i - 1]);
            end
        end
        Hburst = HBURST_SINGLE;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
